// File: rtl/route_dispatch.sv
// route_dispatch: registered stage in front of the 60-in/3-out router.
// Holds a header on the router inputs, samples the decision, then dispatches.
module route_dispatch #(
    parameter int SETTLE_CYC = 1,
    parameter int CREDITS    = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [59:0]      in_hdr,
    output logic [59:0]      rt_x,
    input  logic [2:0]       rt_y,
    output logic [2:0]       out_valid,
    input  logic [2:0]       out_ready,
    output logic [59:0]      out_hdr,
    input  logic [2:0]       credit_ret,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE_CYC);
    localparam logic [3:0] CRED_L   = 4'(CREDITS);

    state_t          state;
    state_t          nstate;
    logic [3:0]      settle;
    logic [1:0]      route_sel;
    logic [1:0]      y_sel;
    logic [2:0][3:0] credit;
    logic [2:0]      cred_nz;
    logic [2:0]      sel_oh;
    logic [2:0]      hs;
    logic            accept;
    logic            eval_done;
    logic            y_none;

    assign in_ready  = (state == IDLE);
    assign busy      = ~in_ready;
    assign accept    = in_valid & in_ready;
    assign eval_done = (state == EVAL) && (settle == 4'd1);
    assign y_none    = (rt_y == 3'b000);

    // Per-port "has credit" flags.
    always_comb begin
        cred_nz = 3'b000;
        for (int p = 0; p < 3; p++) begin
            cred_nz[p] = (credit[p] != 4'd0);
        end
    end

    // Lowest-index set decision bit wins.
    always_comb begin
        y_sel = 2'd0;
        unique casez (rt_y)
            3'b??1:  y_sel = 2'd0;
            3'b?10:  y_sel = 2'd1;
            3'b100:  y_sel = 2'd2;
            default: y_sel = 2'd0;
        endcase
    end

    // One-hot form of the latched route.
    always_comb begin
        sel_oh = 3'b000;
        unique case (route_sel)
            2'd0:    sel_oh = 3'b001;
            2'd1:    sel_oh = 3'b010;
            2'd2:    sel_oh = 3'b100;
            default: sel_oh = 3'b000;
        endcase
    end

    // Offer the header only on the chosen port and only with credit.
    always_comb begin
        out_valid = 3'b000;
        if (state == SEND) begin
            out_valid = sel_oh & cred_nz;
        end
    end

    assign hs = out_valid & out_ready;

    // Next-state logic.
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nstate = EVAL;
                end
            end
            EVAL: begin
                if (settle == 4'd1) begin
                    nstate = y_none ? IDLE : SEND;
                end
            end
            SEND: begin
                if (|hs) begin
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Settle timer: loaded on accept, counts down while evaluating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle <= 4'd0;
        end else if (accept) begin
            settle <= SETTLE_L;
        end else if (state == EVAL) begin
            settle <= settle - 4'd1;
        end
    end

    // Header capture; held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rt_x    <= '0;
            out_hdr <= '0;
        end else if (accept) begin
            rt_x    <= in_hdr;
            out_hdr <= in_hdr;
        end
    end

    // Latch the chosen port when the decision is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            route_sel <= 2'd0;
        end else if (eval_done && !y_none) begin
            route_sel <= y_sel;
        end
    end

    // Saturating count of headers the router sent nowhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (eval_done && y_none && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Per-port credits: a return and a handshake together cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 3; p++) begin
                credit[p] <= CRED_L;
            end
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (hs[p] && !credit_ret[p]) begin
                    credit[p] <= credit[p] - 4'd1;
                end else if (credit_ret[p] && !hs[p]
                             && (credit[p] != CRED_L)) begin
                    credit[p] <= credit[p] + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_route_dispatch.sv
// tb_route_dispatch: directed checks of route_dispatch.
// Default parameters: SETTLE_CYC=1, CREDITS=4, CNT_W=8.
module tb_route_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [59:0] in_hdr;
    logic [59:0] rt_x;
    logic [2:0]  rt_y;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [59:0] out_hdr;
    logic [2:0]  credit_ret;
    logic [7:0]  drop_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int exp_drop = 0;

    route_dispatch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_hdr     (in_hdr),
        .rt_x       (rt_x),
        .rt_y       (rt_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hdr    (out_hdr),
        .credit_ret (credit_ret),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a header and advance to the cycle after the decision edge.
    task automatic accept(input logic [59:0] h, input logic [2:0] y);
        in_hdr   = h;
        rt_y     = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL reset_out_valid got=%b exp=000", out_valid); end
        checks++; if (rt_x !== 60'h0) begin errors++; $display("FAIL reset_rt_x got=%h exp=0", rt_x); end
        checks++; if (out_hdr !== 60'h0) begin errors++; $display("FAIL reset_out_hdr got=%h exp=0", out_hdr); end
        checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop_cnt got=%h exp=00", drop_cnt); end
    endtask

    task automatic test_drop();
        in_hdr = 60'h0; rt_y = 3'b000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drop_eval_ready got=%b exp=0", in_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_eval_busy got=%b exp=1", busy); end
        checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL drop_eval_ov got=%b exp=000", out_valid); end
        tick();
        exp_drop = 1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drop_ready_back got=%b exp=1", in_ready); end
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop); end
        checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL drop_ov got=%b exp=000", out_valid); end
    endtask

    task automatic test_route_and_back_to_back();
        logic [59:0] h1;
        logic [59:0] h2;
        h1 = 60'hABC_DEF0_1234_5678;
        h2 = 60'h135_7924_6801_ACE0;
        out_ready = 3'b010;
        in_hdr = h1; rt_y = 3'b110; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (rt_x !== h1) begin errors++; $display("FAIL route_rt_x got=%h exp=%h", rt_x, h1); end
        checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL route_eval_ov got=%b exp=000", out_valid); end
        tick();
        checks++; if (out_valid !== 3'b010) begin errors++; $display("FAIL route_ov got=%b exp=010", out_valid); end
        checks++; if (out_hdr !== h1) begin errors++; $display("FAIL route_hdr got=%h exp=%h", out_hdr, h1); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL route_send_ready got=%b exp=0", in_ready); end
        in_hdr = h2; rt_y = 3'b000; in_valid = 1'b1;
        tick();
        checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL b2b_ov_after_hs got=%b exp=000", out_valid); end
        checks++; if (rt_x !== h1) begin errors++; $display("FAIL b2b_no_accept got=%h exp=%h", rt_x, h1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (rt_x !== h2) begin errors++; $display("FAIL b2b_accept got=%h exp=%h", rt_x, h2); end
        tick();
        exp_drop++;
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL b2b_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
        out_ready = 3'b000;
    endtask

    task automatic test_backpressure();
        logic [59:0] h3;
        h3 = 60'hFED_CBA9_8765_4321;
        out_ready = 3'b000;
        accept(h3, 3'b100);
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 3'b100) begin errors++; $display("FAIL bp_hold_ov[%0d] got=%b exp=100", i, out_valid); end
            checks++; if (out_hdr !== h3) begin errors++; $display("FAIL bp_hold_hdr[%0d] got=%h exp=%h", i, out_hdr, h3); end
            tick();
        end
        out_ready = 3'b100;
        checks++; if (out_valid !== 3'b100) begin errors++; $display("FAIL bp_6th_ov got=%b exp=100", out_valid); end
        tick();
        checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL bp_done_ov got=%b exp=000", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_done_ready got=%b exp=1", in_ready); end
        out_ready = 3'b000;
    endtask

    task automatic test_drop_saturate();
        while (exp_drop < 255) begin
            accept(60'h5, 3'b000);
            exp_drop++;
        end
        checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL drop_sat_reach got=%h exp=ff", drop_cnt); end
        accept(60'h6, 3'b000);
        checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL drop_sat_hold got=%h exp=ff", drop_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drop_sat_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_credit_exhaust();
        logic [59:0] h;
        out_ready = 3'b001;
        for (int i = 0; i < 4; i++) begin
            h = 60'h100 + 60'(i);
            accept(h, (i % 2 == 0) ? 3'b011 : 3'b111);
            checks++; if (out_valid !== 3'b001) begin errors++; $display("FAIL exh_ov[%0d] got=%b exp=001", i, out_valid); end
            checks++; if (out_hdr !== h) begin errors++; $display("FAIL exh_hdr[%0d] got=%h exp=%h", i, out_hdr, h); end
            tick();
        end
        accept(60'h1FF, 3'b001);
        checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL exh_wait_ov got=%b exp=000", out_valid); end
        repeat (3) tick();
        checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL exh_still_ov got=%b exp=000", out_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exh_busy got=%b exp=1", busy); end
        credit_ret = 3'b001;
        tick();
        credit_ret = 3'b000;
        checks++; if (out_valid !== 3'b001) begin errors++; $display("FAIL exh_ret_ov got=%b exp=001", out_valid); end
        checks++; if (out_hdr !== 60'h1FF) begin errors++; $display("FAIL exh_ret_hdr got=%h exp=1ff", out_hdr); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL exh_done_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_credit_coincide();
        out_ready = 3'b001;
        credit_ret = 3'b001;
        repeat (2) tick();
        credit_ret = 3'b000;
        accept(60'h200, 3'b001);
        checks++; if (out_valid !== 3'b001) begin errors++; $display("FAIL coin_ov got=%b exp=001", out_valid); end
        credit_ret = 3'b001;
        tick();
        credit_ret = 3'b000;
        for (int i = 0; i < 2; i++) begin
            accept(60'h210 + 60'(i), 3'b001);
            checks++; if (out_valid !== 3'b001) begin errors++; $display("FAIL coin_left[%0d] got=%b exp=001", i, out_valid); end
            tick();
        end
        accept(60'h21F, 3'b001);
        checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL coin_empty got=%b exp=000", out_valid); end
        credit_ret = 3'b001;
        tick();
        credit_ret = 3'b000;
        tick();
    endtask

    task automatic test_credit_saturate();
        out_ready = 3'b001;
        credit_ret = 3'b001;
        repeat (8) tick();
        credit_ret = 3'b000;
        for (int i = 0; i < 4; i++) begin
            accept(60'h300 + 60'(i), 3'b001);
            checks++; if (out_valid !== 3'b001) begin errors++; $display("FAIL sat_ov[%0d] got=%b exp=001", i, out_valid); end
            tick();
        end
        accept(60'h3FF, 3'b001);
        checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL sat_5th got=%b exp=000", out_valid); end
    endtask

    task automatic test_reset_mid_send();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL rst_ov got=%b exp=000", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
        checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL rst_drop got=%h exp=00", drop_cnt); end
        checks++; if (out_hdr !== 60'h0) begin errors++; $display("FAIL rst_hdr got=%h exp=0", out_hdr); end
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 3'b010;
        for (int i = 0; i < 4; i++) begin
            accept(60'h400 + 60'(i), 3'b010);
            checks++; if (out_valid !== 3'b010) begin errors++; $display("FAIL post_rst_p1[%0d] got=%b exp=010", i, out_valid); end
            tick();
        end
        accept(60'h4FF, 3'b010);
        checks++; if (out_valid !== 3'b000) begin errors++; $display("FAIL post_rst_p1_5th got=%b exp=000", out_valid); end
        checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL post_rst_drop got=%h exp=00", drop_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_hdr = '0;
        rt_y = 3'b000;
        out_ready = 3'b000;
        credit_ret = 3'b000;
        repeat (2) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_drop();
        test_route_and_back_to_back();
        test_backpressure();
        test_drop_saturate();
        test_credit_exhaust();
        test_credit_coincide();
        test_credit_saturate();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
